// File: rtl/iter_div.sv
// Iterative radix-2 restoring divider for RV64M DIV/DIVU/REM/REMU and their W forms.
// One operation in flight; 64 restoring steps plus one fix-up cycle, while
// divide-by-zero and signed overflow are answered straight from the accept cycle.
module iter_div #(
    parameter int EU_CTL_LEN      = 4,
    parameter int ROB_IDX_LEN     = 4,
    parameter int EXCEPT_CODE_LEN = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       flush_i,
    input  logic                       valid_i,
    output logic                       ready_o,
    input  logic [EU_CTL_LEN-1:0]      ctl_i,
    input  logic [ROB_IDX_LEN-1:0]     rob_idx_i,
    input  logic [63:0]                rs1_value_i,
    input  logic [63:0]                rs2_value_i,
    output logic                       valid_o,
    input  logic                       ready_i,
    output logic [ROB_IDX_LEN-1:0]     rob_idx_o,
    output logic [63:0]                result_o,
    output logic                       except_raised_o,
    output logic [EXCEPT_CODE_LEN-1:0] except_code_o
);

    typedef enum logic [1:0] {IDLE, BUSY, FIX, DONE} state_t;

    state_t                   state_q, state_d;
    logic                     accept;
    logic [64:0]              rem_q;
    logic [63:0]              quo_q;
    logic [63:0]              dvs_q;
    logic [5:0]               cnt_q;
    logic [2:0]               ctl_q;
    logic [ROB_IDX_LEN-1:0]   rob_idx_q;
    logic                     a_neg_q, b_neg_q;

    logic                     op_w, op_rem, op_uns;
    logic signed [63:0]       a_ext, b_ext;
    logic [63:0]              a_mag, b_mag;
    logic                     a_neg, b_neg, div_zero, sgn_ovf, special;
    logic [64:0]              rem_sh, diff;
    logic [63:0]              quo_sh;
    logic                     unused_bits;

    function automatic logic [63:0] sext32(input logic [63:0] v);
        return {{32{v[31]}}, v[31:0]};
    endfunction

    // Result of a special case, computed from the extended dividend.
    function automatic logic [63:0] special_result(input logic is_rem, input logic is_w,
                                                   input logic dz, input logic [63:0] a);
        logic [63:0] res;
        if (dz) res = is_rem ? a : '1;
        else    res = is_rem ? '0 : a;
        return is_w ? sext32(res) : res;
    endfunction

    // Sign correction of the magnitude quotient/remainder plus W extension.
    function automatic logic [63:0] fix_result(input logic [2:0] op, input logic an,
                                               input logic bn, input logic [63:0] quo,
                                               input logic [63:0] rem);
        logic [63:0] q, r, res;
        q   = (an ^ bn) ? (~quo + 64'd1) : quo;
        r   = an ? (~rem + 64'd1) : rem;
        res = op[1] ? r : q;
        return op[2] ? sext32(res) : res;
    endfunction

    assign except_raised_o = 1'b0;
    assign except_code_o   = '0;
    assign valid_o         = (state_q == DONE);
    // Upper ctl bits carry no meaning here; rem_q[64] is always clear after a step.
    assign unused_bits     = ^{ctl_i, rem_q[64]};

    // Operand extension, magnitudes and special-case detection for the accept cycle.
    always_comb begin
        op_w   = ctl_i[2];
        op_rem = ctl_i[1];
        op_uns = ctl_i[0];
        a_ext  = $signed(rs1_value_i);
        b_ext  = $signed(rs2_value_i);
        if (op_w) begin
            a_ext = op_uns ? $signed({32'b0, rs1_value_i[31:0]})
                           : $signed({{32{rs1_value_i[31]}}, rs1_value_i[31:0]});
            b_ext = op_uns ? $signed({32'b0, rs2_value_i[31:0]})
                           : $signed({{32{rs2_value_i[31]}}, rs2_value_i[31:0]});
        end
        a_neg    = !op_uns && (a_ext < 0);
        b_neg    = !op_uns && (b_ext < 0);
        a_mag    = a_neg ? $unsigned(-a_ext) : $unsigned(a_ext);
        b_mag    = b_neg ? $unsigned(-b_ext) : $unsigned(b_ext);
        div_zero = (b_ext == 64'sd0);
        sgn_ovf  = !op_uns && (b_ext == -64'sd1) &&
                   (a_ext == (op_w ? 64'shFFFF_FFFF_8000_0000 : 64'sh8000_0000_0000_0000));
        special  = div_zero || sgn_ovf;
    end

    // One restoring step: shift {rem, quo}, trial-subtract, keep if non-negative.
    always_comb begin
        rem_sh = {rem_q[63:0], quo_q[63]};
        diff   = rem_sh - {1'b0, dvs_q};
        quo_sh = {quo_q[62:0], ~diff[64]};
    end

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Next state, handshake and accept decision; flush overrides everything.
    always_comb begin
        state_d = state_q;
        ready_o = 1'b0;
        accept  = 1'b0;
        case (state_q)
            IDLE: ready_o = 1'b1;
            BUSY: if (cnt_q == 6'd63) state_d = FIX;
            FIX:  state_d = DONE;
            DONE: begin
                ready_o = ready_i;
                if (ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        accept = valid_i && ready_o && !flush_i;
        if (accept)  state_d = special ? DONE : BUSY;
        if (flush_i) state_d = IDLE;
    end

    // Datapath: latch on accept, iterate in BUSY, register the result in FIX.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            cnt_q     <= '0;
            ctl_q     <= '0;
            rob_idx_q <= '0;
            a_neg_q   <= 1'b0;
            b_neg_q   <= 1'b0;
            result_o  <= '0;
            rob_idx_o <= '0;
        end else if (accept) begin
            rem_q     <= '0;
            quo_q     <= a_mag;
            dvs_q     <= b_mag;
            cnt_q     <= '0;
            ctl_q     <= ctl_i[2:0];
            rob_idx_q <= rob_idx_i;
            a_neg_q   <= a_neg;
            b_neg_q   <= b_neg;
            if (special) begin
                result_o  <= special_result(op_rem, op_w, div_zero, $unsigned(a_ext));
                rob_idx_o <= rob_idx_i;
            end
        end else if (!flush_i && state_q == BUSY) begin
            rem_q <= diff[64] ? rem_sh : diff;
            quo_q <= quo_sh;
            cnt_q <= cnt_q + 6'd1;
        end else if (!flush_i && state_q == FIX) begin
            result_o  <= fix_result(ctl_q, a_neg_q, b_neg_q, quo_q, rem_q[63:0]);
            rob_idx_o <= rob_idx_q;
        end
    end

endmodule

// File: tb/tb_iter_div.sv
// Directed bench for iter_div: reset, unsigned/signed division, special cases,
// backpressure with back-to-back accept, flush and mid-operation reset.
module tb_iter_div;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        flush_i;
    logic        valid_i;
    logic        ready_o;
    logic [3:0]  ctl_i;
    logic [3:0]  rob_idx_i;
    logic [63:0] rs1_value_i;
    logic [63:0] rs2_value_i;
    logic        valid_o;
    logic        ready_i;
    logic [3:0]  rob_idx_o;
    logic [63:0] result_o;
    logic        except_raised_o;
    logic [3:0]  except_code_o;

    int checks = 0;
    int errors = 0;

    iter_div #(.EU_CTL_LEN(4), .ROB_IDX_LEN(4), .EXCEPT_CODE_LEN(4)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .flush_i(flush_i), .valid_i(valid_i),
        .ready_o(ready_o), .ctl_i(ctl_i), .rob_idx_i(rob_idx_i),
        .rs1_value_i(rs1_value_i), .rs2_value_i(rs2_value_i), .valid_o(valid_o),
        .ready_i(ready_i), .rob_idx_o(rob_idx_o), .result_o(result_o),
        .except_raised_o(except_raised_o), .except_code_o(except_code_o)
    );

    always #5 clk = ~clk;

    // Present one operation, let it be accepted, scramble the inputs, then wait
    // (bounded) for valid_o. lat counts cycles from the accept cycle (cycle 0).
    task automatic do_op(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                         input logic [3:0] rob, output int lat);
        ctl_i       = {1'b1, op};
        rob_idx_i   = rob;
        rs1_value_i = a;
        rs2_value_i = b;
        valid_i     = 1'b1;
        @(posedge clk); #1;
        valid_i     = 1'b0;
        ctl_i       = 4'h0;
        rob_idx_i   = 4'hF;
        rs1_value_i = 64'hDEAD_BEEF_0123_4567;
        rs2_value_i = 64'd3;
        lat = 1;
        while (!valid_o && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic drain;
        ready_i = 1'b1;
        @(posedge clk); #1;
        ready_i = 1'b0;
    endtask

    task automatic test_reset;
        checks++;
        if (ready_o !== 1'b1 || valid_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_handshake: ready_o=%b valid_o=%b, required 1/0", ready_o, valid_o);
        end
        checks++;
        if (result_o !== 64'd0 || rob_idx_o !== 4'd0) begin
            errors++;
            $display("FAIL reset_outputs: result_o=%h rob_idx_o=%0d, required 0/0", result_o, rob_idx_o);
        end
        checks++;
        if (except_raised_o !== 1'b0 || except_code_o !== 4'd0) begin
            errors++;
            $display("FAIL reset_except: raised=%b code=%0d, required 0/0", except_raised_o, except_code_o);
        end
    endtask

    task automatic test_unsigned;
        logic [2:0]  op [4];
        logic [63:0] a [4], b [4], exp [4];
        int          lat;
        op[0] = 3'd1; a[0] = 64'd100;        b[0] = 64'd7; exp[0] = 64'd14;
        op[1] = 3'd3; a[1] = 64'd100;        b[1] = 64'd7; exp[1] = 64'd2;
        op[2] = 3'd5; a[2] = 64'hFFFF_FFFF;  b[2] = 64'd1; exp[2] = 64'hFFFF_FFFF_FFFF_FFFF;
        op[3] = 3'd1; a[3] = 64'hFFFF_FFFF_FFFF_FFFF; b[3] = 64'd2; exp[3] = 64'h7FFF_FFFF_FFFF_FFFF;
        for (int i = 0; i < 4; i++) begin
            do_op(op[i], a[i], b[i], 4'd3, lat);
            checks++;
            if (lat !== 66) begin
                errors++;
                $display("FAIL unsigned[%0d]_latency: got %0d, required 66", i, lat);
            end
            checks++;
            if (result_o !== exp[i]) begin
                errors++;
                $display("FAIL unsigned[%0d]_result: got %h, required %h", i, result_o, exp[i]);
            end
            checks++;
            if (rob_idx_o !== 4'd3) begin
                errors++;
                $display("FAIL unsigned[%0d]_rob: got %0d, required 3", i, rob_idx_o);
            end
            drain();
            checks++;
            if (valid_o !== 1'b0) begin
                errors++;
                $display("FAIL unsigned[%0d]_drain: valid_o=%b, required 0", i, valid_o);
            end
        end
    endtask

    task automatic test_signed;
        logic [2:0]  op [4];
        logic [63:0] a [4], b [4], exp [4];
        int          lat;
        op[0] = 3'd0; a[0] = 64'hFFFF_FFFF_FFFF_FFF9; b[0] = 64'd2; exp[0] = 64'hFFFF_FFFF_FFFF_FFFD;
        op[1] = 3'd2; a[1] = 64'hFFFF_FFFF_FFFF_FFF9; b[1] = 64'd2; exp[1] = 64'hFFFF_FFFF_FFFF_FFFF;
        op[2] = 3'd2; a[2] = 64'd7; b[2] = 64'hFFFF_FFFF_FFFF_FFFE; exp[2] = 64'd1;
        op[3] = 3'd4; a[3] = 64'h1234_5678_FFFF_FFF1; b[3] = 64'd3; exp[3] = 64'hFFFF_FFFF_FFFF_FFFB;
        for (int i = 0; i < 4; i++) begin
            do_op(op[i], a[i], b[i], 4'(i + 8), lat);
            checks++;
            if (lat !== 66) begin
                errors++;
                $display("FAIL signed[%0d]_latency: got %0d, required 66", i, lat);
            end
            checks++;
            if (result_o !== exp[i]) begin
                errors++;
                $display("FAIL signed[%0d]_result: got %h, required %h", i, result_o, exp[i]);
            end
            checks++;
            if (rob_idx_o !== 4'(i + 8)) begin
                errors++;
                $display("FAIL signed[%0d]_rob: got %0d, required %0d", i, rob_idx_o, i + 8);
            end
            drain();
        end
    endtask

    task automatic test_special;
        logic [2:0]  op [6];
        logic [63:0] a [6], b [6], exp [6];
        int          lat;
        op[0] = 3'd0; a[0] = 64'd5;          b[0] = 64'd0; exp[0] = 64'hFFFF_FFFF_FFFF_FFFF;
        op[1] = 3'd3; a[1] = 64'd5;          b[1] = 64'd0; exp[1] = 64'd5;
        op[2] = 3'd6; a[2] = 64'h1_8000_0000; b[2] = 64'd0; exp[2] = 64'hFFFF_FFFF_8000_0000;
        op[3] = 3'd0; a[3] = 64'h8000_0000_0000_0000; b[3] = 64'hFFFF_FFFF_FFFF_FFFF;
        exp[3] = 64'h8000_0000_0000_0000;
        op[4] = 3'd2; a[4] = 64'h8000_0000_0000_0000; b[4] = 64'hFFFF_FFFF_FFFF_FFFF; exp[4] = 64'd0;
        op[5] = 3'd4; a[5] = 64'h8000_0000;  b[5] = 64'hFFFF_FFFF; exp[5] = 64'hFFFF_FFFF_8000_0000;
        for (int i = 0; i < 6; i++) begin
            do_op(op[i], a[i], b[i], 4'(i), lat);
            checks++;
            if (lat !== 1) begin
                errors++;
                $display("FAIL special[%0d]_latency: got %0d, required 1", i, lat);
            end
            checks++;
            if (result_o !== exp[i] || rob_idx_o !== 4'(i)) begin
                errors++;
                $display("FAIL special[%0d]_result: got %h rob %0d, required %h rob %0d",
                         i, result_o, rob_idx_o, exp[i], i);
            end
            drain();
        end
    endtask

    task automatic test_back_to_back;
        int lat;
        do_op(3'd1, 64'd100, 64'd7, 4'd5, lat);
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            checks++;
            if (valid_o !== 1'b1 || ready_o !== 1'b0 || result_o !== 64'd14 || rob_idx_o !== 4'd5) begin
                errors++;
                $display("FAIL stall[%0d]: valid=%b ready=%b result=%h rob=%0d, required 1/0/e/5",
                         c, valid_o, ready_o, result_o, rob_idx_o);
            end
        end
        ctl_i = 4'd1; rob_idx_i = 4'd6; rs1_value_i = 64'd1000; rs2_value_i = 64'd10;
        valid_i = 1'b1;
        #1;
        checks++;
        if (ready_o !== 1'b0) begin
            errors++;
            $display("FAIL b2b_ready_low: ready_o=%b, required 0", ready_o);
        end
        ready_i = 1'b1;
        #1;
        checks++;
        if (ready_o !== 1'b1) begin
            errors++;
            $display("FAIL b2b_ready_high: ready_o=%b, required 1", ready_o);
        end
        @(posedge clk); #1;
        valid_i = 1'b0; ready_i = 1'b0; rs1_value_i = 64'd77; rs2_value_i = 64'd0;
        checks++;
        if (valid_o !== 1'b0 || ready_o !== 1'b0) begin
            errors++;
            $display("FAIL b2b_busy: valid=%b ready=%b, required 0/0", valid_o, ready_o);
        end
        lat = 1;
        while (!valid_o && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        checks++;
        if (lat !== 66 || result_o !== 64'd100 || rob_idx_o !== 4'd6) begin
            errors++;
            $display("FAIL b2b_result: lat=%0d result=%h rob=%0d, required 66/64/6", lat, result_o, rob_idx_o);
        end
        drain();
    endtask

    task automatic test_flush;
        int lat;
        int seen;
        ctl_i = 4'd1; rob_idx_i = 4'd2; rs1_value_i = 64'd100; rs2_value_i = 64'd7;
        valid_i = 1'b1;
        @(posedge clk); #1;
        valid_i = 1'b0;
        for (int c = 1; c < 30; c++) begin
            @(posedge clk); #1;
        end
        flush_i = 1'b1;
        valid_i = 1'b1;
        rs1_value_i = 64'd9; rs2_value_i = 64'd0;
        @(posedge clk); #1;
        flush_i = 1'b0;
        valid_i = 1'b0;
        checks++;
        if (ready_o !== 1'b1 || valid_o !== 1'b0) begin
            errors++;
            $display("FAIL flush_idle: ready=%b valid=%b, required 1/0", ready_o, valid_o);
        end
        seen = 0;
        for (int c = 0; c < 70; c++) begin
            @(posedge clk); #1;
            if (valid_o) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL flush_no_result: valid_o cycles=%0d, required 0", seen);
        end
        do_op(3'd0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 4'd4, lat);
        checks++;
        if (lat !== 66 || result_o !== 64'hFFFF_FFFF_FFFF_FFFD || rob_idx_o !== 4'd4) begin
            errors++;
            $display("FAIL flush_recover: lat=%0d result=%h rob=%0d, required 66/fffffffffffffffd/4",
                     lat, result_o, rob_idx_o);
        end
        drain();
    endtask

    task automatic test_reset_mid;
        int lat;
        ctl_i = 4'd1; rob_idx_i = 4'd7; rs1_value_i = 64'd100; rs2_value_i = 64'd7;
        valid_i = 1'b1;
        @(posedge clk); #1;
        valid_i = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
        end
        rst_ni = 1'b0;
        #1;
        checks++;
        if (ready_o !== 1'b1 || valid_o !== 1'b0 || result_o !== 64'd0 || rob_idx_o !== 4'd0) begin
            errors++;
            $display("FAIL reset_mid: ready=%b valid=%b result=%h rob=%0d, required 1/0/0/0",
                     ready_o, valid_o, result_o, rob_idx_o);
        end
        @(posedge clk); #2;
        rst_ni = 1'b1;
        @(posedge clk); #1;
        do_op(3'd3, 64'd100, 64'd7, 4'd1, lat);
        checks++;
        if (lat !== 66 || result_o !== 64'd2 || rob_idx_o !== 4'd1) begin
            errors++;
            $display("FAIL reset_recover: lat=%0d result=%h rob=%0d, required 66/2/1", lat, result_o, rob_idx_o);
        end
        drain();
    endtask

    initial begin
        rst_ni = 1'b0; flush_i = 1'b0; valid_i = 1'b0; ready_i = 1'b0;
        ctl_i = '0; rob_idx_i = '0; rs1_value_i = '0; rs2_value_i = '0;
        #1;
        test_reset();
        @(posedge clk); @(posedge clk); #2;
        rst_ni = 1'b1;
        @(posedge clk); #1;
        test_unsigned();
        test_signed();
        test_special();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/iter_div.md
# iter_div

Iterative radix-2 integer divider, and the execution unit behind the divider reservation station. It accepts one RV64M divide/remainder operation per handshake from the RS issue side (`eu_valid_o`/`eu_ready_i`). It computes the quotient or remainder over 64 restoring steps, then returns the result with its ROB index on the RS writeback side (`eu_valid_i`/`eu_ready_o`). Divide-by-zero and signed overflow are answered in one cycle without iterating.

## Interface
- `EU_CTL_LEN`, default 4: width of `ctl_i`.
- `XLEN`, fixed at 64 by `len5_pkg`; not a parameter.
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `flush_i`  in  1  synchronous flush; aborts any operation in flight.
- `valid_i`  in  1  RS has an operation ready.
- `ready_o`  out  1  divider can accept an operation this cycle.
- `ctl_i`  in  EU_CTL_LEN  operation code.
- `rob_idx_i`  in  rob_idx_t  destination ROB index.
- `rs1_value_i`  in  XLEN  dividend.
- `rs2_value_i`  in  XLEN  divisor.
- `valid_o`  out  1  result valid.
- `ready_i`  in  1  RS accepts the result.
- `rob_idx_o`  out  rob_idx_t  ROB index of the result.
- `result_o`  out  XLEN  quotient or remainder.
- `except_raised_o`  out  1  constant 0; RV64M division raises no exceptions.
- `except_code_o`  out  except_code_t  constant 0.

## Operation
- `ctl_i` codes (low 3 bits; upper bits ignored):
  - 0 DIV, 1 DIVU, 2 REM, 3 REMU
  - 4 DIVW, 5 DIVUW, 6 REMW, 7 REMUW
- W variants:
  - Operands are the low 32 bits, sign-extended for signed ops and zero-extended for unsigned ops, to 64 bits.
  - The final result is bits [31:0] sign-extended to 64 bits, for all four W ops, DIVUW/REMUW included.
- Signed ops:
  - Divide magnitudes unsigned.
  - Quotient is negated if the operand signs differ.
  - Remainder takes the sign of the dividend.
- Special cases, detected at accept and evaluated on the extended operands:
  - Divisor = 0: quotient = all ones; remainder = dividend (both 32-bit-sign-extended for W).
  - Signed overflow (dividend = minimum signed value, divisor = −1, for 64- or 32-bit width as applicable): quotient = dividend; remainder = 0.
- Datapath registers:
  - Remainder accumulator, 65 bits.
  - Quotient/dividend shift register, 64 bits.
  - Divisor magnitude, 64 bits.
  - 6-bit step counter.
  - Latched ctl, rob_idx and the sign flags.
- Restoring step: shift {rem, quo} left by 1, trial-subtract the divisor, keep the difference if it is non-negative, and shift in the quotient bit.
- FSM states:
  - IDLE: `ready_o`=1. On `valid_i`, latch the operands; go to DONE if a special case applies, otherwise to BUSY with counter = 0.
  - BUSY: one step per cycle. Counter increments and wraps from 63 to 0; the wrap edge goes to FIX.
  - FIX: apply sign correction and W extension, register `result_o`, go to DONE.
  - DONE: `valid_o`=1 while outputs hold steady. When `ready_i`=1, go to IDLE, or directly accept a new operation if `valid_i`=1.
- `ready_o` is 1 in IDLE, and in DONE when `ready_i`=1. This allows back-to-back operation with no bubble.
- `flush_i` takes priority over everything:
  - Next state is IDLE; `valid_o` is 0 from the next cycle.
  - No operation is accepted in a cycle where `flush_i`=1.
  - A result in DONE is discarded even if `ready_i`=1 in that cycle.

## Timing
- Reset values (outputs and datapath registers):
  - State IDLE, so `ready_o`=1 and `valid_o`=0.
  - `rob_idx_o`=0, `result_o`=0, `except_raised_o`=0, `except_code_o`=0.
  - Counter and all datapath registers = 0.
- Reset mid-operation aborts immediately, with no result.
- Latency, numbering the accept cycle (the cycle where `valid_i`&`ready_o`) as cycle 0:
  - Normal operation: BUSY in cycles 1–64, FIX in cycle 65, `valid_o` from cycle 66.
  - Special case: `valid_o` from cycle 1.
- Throughput:
  - One operation per 67 cycles with `ready_i` held high (66 cycles with back-to-back accept in DONE).
  - One operation per 2 cycles for special cases.
- Stall: while `valid_o`=1 and `ready_i`=0, `result_o` and `rob_idx_o` are stable.
- Inputs are sampled only in the accept cycle; changes to them while BUSY have no effect.

## Test plan
- DIVU: 100 / 7, rob_idx 3 → `valid_o` in cycle 66, `result_o`=14, `rob_idx_o`=3. REMU on the same operands → 2.
- Signed: DIV −7 / 2 → 0xFFFF_FFFF_FFFF_FFFD (−3). REM −7 / 2 → 0xFFFF_FFFF_FFFF_FFFF (−1). REM 7 / −2 → 1.
- Divide by zero: DIV 5 / 0 → all ones in cycle 1. REMU 5 / 0 → 5. REMW with rs1=0x1_8000_0000, rs2=0 → 0xFFFF_FFFF_8000_0000.
- Overflow:
  - DIV 0x8000_0000_0000_0000 / −1 → 0x8000_0000_0000_0000; REM → 0.
  - DIVW 0x8000_0000 / 0xFFFF_FFFF → 0xFFFF_FFFF_8000_0000.
  - DIVUW 0xFFFF_FFFF / 1 → 0xFFFF_FFFF_FFFF_FFFF.
- Backpressure and back-to-back: hold `ready_i`=0 for 10 cycles in DONE → outputs stable and `ready_o`=0. Then assert `ready_i` with `valid_i` already high → the next operation is accepted in that same cycle.
- Flush/reset:
  - Assert `flush_i` in BUSY cycle 30 → IDLE next cycle, no `valid_o`, and a new operation completes correctly.
  - Assert `rst_ni`=0 mid-BUSY → all outputs return to reset values immediately.
